// File: rtl/fc_argmax.sv
// Argmax sink for the final FC layer: folds activation beats into a running (max, idx)
// and reports the winning class on a valid/ack handshake. Define FC_ARGMAX_SIGNED_EN for signed compare.

module fc_argmax_lane #(
  parameter int H     = 0,
  parameter int C     = 0,
  parameter int EPT   = 64,
  parameter int NC    = 1,
  parameter int ON    = 10,
  parameter int CNT_W = 7,
  parameter int IDX_W = 4
) (
  input  logic [CNT_W-1:0] cnt_i,
  output logic             vld_o,
  output logic [IDX_W-1:0] idx_o
);
  int slot, n;
  always_comb begin
    slot  = int'(cnt_i) * NC + C;
    n     = H * EPT + slot;
    vld_o = (slot < EPT) && (n < ON);
    idx_o = IDX_W'(n);
  end
endmodule

module fc_argmax #(
  parameter int OUTPUT_NEURONS = 10,
  parameter int XBAR_SIZE      = 512,
  parameter int DATA_SIZE      = 8,
  parameter int OBUF_BUS_WIDTH = 46,
  localparam int OBUF_DATA_SIZE = (DATA_SIZE == 1) ? $clog2(XBAR_SIZE)
                                                   : 2*DATA_SIZE + $clog2(XBAR_SIZE),
  localparam int NC_RAW         = OBUF_BUS_WIDTH / OBUF_DATA_SIZE,
  localparam int NUM_CHANNELS   = (NC_RAW < 1) ? 1 : NC_RAW,
  localparam int H_CIM_TILES    = (OUTPUT_NEURONS*DATA_SIZE + XBAR_SIZE - 1) / XBAR_SIZE,
  localparam int EPT            = XBAR_SIZE / DATA_SIZE,
  localparam int NUM_ADDR_OBUF  = (EPT + NUM_CHANNELS - 1) / NUM_CHANNELS,
  localparam int IDX_W          = (OUTPUT_NEURONS > 1) ? $clog2(OUTPUT_NEURONS) : 1,
  localparam int CNT_W          = $clog2(NUM_ADDR_OBUF + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_we,
  input  logic [DATA_SIZE-1:0] i_data [H_CIM_TILES-1:0][NUM_CHANNELS-1:0],
  input  logic                 i_start,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [IDX_W-1:0]     o_class,
  output logic [DATA_SIZE-1:0] o_score,
  input  logic                 i_ack
);

`ifdef FC_ARGMAX_SIGNED_EN
  localparam logic [DATA_SIZE-1:0] SCORE_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
`else
  localparam logic [DATA_SIZE-1:0] SCORE_MIN = '0;
`endif

  function automatic logic gt(input logic [DATA_SIZE-1:0] a, input logic [DATA_SIZE-1:0] b);
`ifdef FC_ARGMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   have_q, have_d;
  logic [DATA_SIZE-1:0]   max_q, max_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic                   ready_q, valid_q;
  logic [IDX_W-1:0]       class_q;
  logic [DATA_SIZE-1:0]   score_q;

  logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0]            lane_vld;
  logic [H_CIM_TILES-1:0][NUM_CHANNELS-1:0][IDX_W-1:0] lane_idx;

  for (genvar h = 0; h < H_CIM_TILES; h++) begin : g_tile
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      fc_argmax_lane #(
        .H(h), .C(c), .EPT(EPT), .NC(NUM_CHANNELS), .ON(OUTPUT_NEURONS),
        .CNT_W(CNT_W), .IDX_W(IDX_W)
      ) u_lane (
        .cnt_i (cnt_q),
        .vld_o (lane_vld[h][c]),
        .idx_o (lane_idx[h][c])
      );
    end
  end

  logic beat_acc, start_acc;
  assign beat_acc  = ready_q && i_we && (cnt_q < CNT_W'(NUM_ADDR_OBUF));
  assign start_acc = ready_q && i_start;

  // Lanes are scanned in ascending neuron order, so strict '>' keeps the lowest index on ties.
  logic                 bv;
  logic [DATA_SIZE-1:0] bmax;
  logic [IDX_W-1:0]     bidx;
  always_comb begin
    bv   = 1'b0;
    bmax = '0;
    bidx = '0;
    for (int h = 0; h < H_CIM_TILES; h++)
      for (int c = 0; c < NUM_CHANNELS; c++)
        if (lane_vld[h][c] && (!bv || gt(i_data[h][c], bmax))) begin
          bv   = 1'b1;
          bmax = i_data[h][c];
          bidx = lane_idx[h][c];
        end
    have_d = have_q;
    max_d  = max_q;
    idx_d  = idx_q;
    if (beat_acc && bv && (!have_q || gt(bmax, max_q))) begin
      have_d = 1'b1;
      max_d  = bmax;
      idx_d  = bidx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      have_q  <= 1'b0;
      max_q   <= '0;
      idx_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      class_q <= '0;
      score_q <= '0;
    end else begin
      case (state_q)
        IDLE, COLLECT: begin
          // A beat arriving with start is folded in via the _d terms before latching.
          if (start_acc) begin
            state_q <= DONE;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            class_q <= have_d ? idx_d : '0;
            score_q <= have_d ? max_d : SCORE_MIN;
          end else if (beat_acc) begin
            state_q <= COLLECT;
            cnt_q   <= cnt_q + 1'b1;
            have_q  <= have_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
          end
        end
        DONE: begin
          if (i_ack && valid_q) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            have_q  <= 1'b0;
            max_q   <= '0;
            idx_q   <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_class = class_q;
  assign o_score = score_q;

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax at default parameters (1 tile, 1 channel, 64 beats/run).

module tb_fc_argmax;
  logic       clk = 1'b0;
  logic       rst;
  logic       i_we, i_start, i_ack;
  logic [7:0] i_data [0:0][0:0];
  logic       o_ready, o_valid;
  logic [3:0] o_class;
  logic [7:0] o_score;

  typedef struct {
    logic [3:0] cls;
    logic [7:0] score;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_mis = 0;

`ifdef FC_ARGMAX_SIGNED_EN
  localparam logic [7:0] SMIN = 8'h80;
`else
  localparam logic [7:0] SMIN = 8'h00;
`endif

  always #5 clk = ~clk;

  fc_argmax dut (
    .clk     (clk),
    .rst     (rst),
    .i_we    (i_we),
    .i_data  (i_data),
    .i_start (i_start),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .o_class (o_class),
    .o_score (o_score),
    .i_ack   (i_ack)
  );

  task automatic beat(input logic [7:0] v, input logic st);
    i_we = 1'b1; i_data[0][0] = v; i_start = st;
    @(posedge clk); #1;
    i_we = 1'b0; i_start = 1'b0;
  endtask

  task automatic start_only();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic ack();
    i_ack = 1'b1;
    @(posedge clk); #1;
    i_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_we = 0; i_start = 0; i_ack = 0; i_data[0][0] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({o_ready, o_valid, o_class, o_score} !== {1'b1, 1'b0, 4'd0, 8'h00}) begin
      n_mis++;
      $display("FAIL reset: ready=%0b valid=%0b class=%0d score=%h, required 1 0 0 00",
               o_ready, o_valid, o_class, o_score);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [7:0] v [10];
    v = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd2, 8'd0, 8'd5, 8'd4, 8'd8, 8'd6};
    for (int k = 0; k < 66; k++) beat((k < 10) ? v[k] : 8'hFF, 1'b0);
    sb.push_back('{4'd3, 8'h09});
    start_only();
    e = sb.pop_front();
    n_cmp++;
    if (o_valid !== 1'b1 || o_class !== e.cls || o_score !== e.score) begin
      n_mis++;
      $display("FAIL basic: valid=%0b class=%0d score=%h, required 1 %0d %h",
               o_valid, o_class, o_score, e.cls, e.score);
    end
    ack();
  endtask

  task automatic test_tie();
    for (int k = 0; k < 10; k++) beat(8'd5, 1'b0);
    sb.push_back('{4'd0, 8'd5});
    start_only();
    e = sb.pop_front();
    n_cmp++;
    if (o_valid !== 1'b1 || o_class !== e.cls || o_score !== e.score) begin
      n_mis++;
      $display("FAIL tie_all: valid=%0b class=%0d score=%h, required 1 %0d %h",
               o_valid, o_class, o_score, e.cls, e.score);
    end
    ack();
    for (int k = 0; k < 10; k++) beat((k == 2 || k == 7) ? 8'd200 : 8'd1, 1'b0);
    sb.push_back('{4'd2, 8'd200});
    start_only();
    e = sb.pop_front();
    n_cmp++;
    if (o_valid !== 1'b1 || o_class !== e.cls || o_score !== e.score) begin
      n_mis++;
      $display("FAIL tie_pair: valid=%0b class=%0d score=%h, required 1 %0d %h",
               o_valid, o_class, o_score, e.cls, e.score);
    end
    ack();
  endtask

  task automatic test_signed();
    logic [7:0] v [10];
    v = '{8'h80, 8'h90, 8'h10, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'h20, 8'h00, 8'h05};
    for (int k = 0; k < 10; k++) beat(v[k], 1'b0);
`ifdef FC_ARGMAX_SIGNED_EN
    sb.push_back('{4'd3, 8'h7F});
`else
    sb.push_back('{4'd4, 8'hFF});
`endif
    start_only();
    e = sb.pop_front();
    n_cmp++;
    if (o_valid !== 1'b1 || o_class !== e.cls || o_score !== e.score) begin
      n_mis++;
      $display("FAIL signed: valid=%0b class=%0d score=%h, required 1 %0d %h",
               o_valid, o_class, o_score, e.cls, e.score);
    end
    ack();
  endtask

  task automatic test_handshake();
    beat(8'd10, 1'b0); beat(8'd50, 1'b0); beat(8'd20, 1'b0); beat(8'd40, 1'b0);
    sb.push_back('{4'd1, 8'd50});
    start_only();
    e = sb.pop_front();
    n_cmp++;
    if (o_valid !== 1'b1 || o_class !== e.cls || o_score !== e.score) begin
      n_mis++;
      $display("FAIL hs_result: valid=%0b class=%0d score=%h, required 1 %0d %h",
               o_valid, o_class, o_score, e.cls, e.score);
    end
    for (int i = 0; i < 5; i++) begin
      i_we = 1'b1; i_start = 1'b1; i_data[0][0] = 8'hFF;
      @(posedge clk); #1;
      n_cmp++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_class !== e.cls || o_score !== e.score) begin
        n_mis++;
        $display("FAIL hs_hold%0d: valid=%0b ready=%0b class=%0d score=%h, required 1 0 %0d %h",
                 i, o_valid, o_ready, o_class, o_score, e.cls, e.score);
      end
    end
    i_we = 1'b0; i_start = 1'b0;
    ack();
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL hs_release: valid=%0b ready=%0b, required 0 1", o_valid, o_ready);
    end
    ack();
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_mis++;
      $display("FAIL hs_idle_ack: valid=%0b ready=%0b, required 0 1", o_valid, o_ready);
    end
  endtask

  task automatic test_edges();
    for (int k = 0; k < 9; k++) beat(8'(k * 2), 1'b0);
    sb.push_back('{4'd9, 8'd100});
    beat(8'd100, 1'b1);
    e = sb.pop_front();
    n_cmp++;
    if (o_valid !== 1'b1 || o_class !== e.cls || o_score !== e.score) begin
      n_mis++;
      $display("FAIL start_with_beat: valid=%0b class=%0d score=%h, required 1 %0d %h",
               o_valid, o_class, o_score, e.cls, e.score);
    end
    ack();
    sb.push_back('{4'd0, SMIN});
    start_only();
    e = sb.pop_front();
    n_cmp++;
    if (o_valid !== 1'b1 || o_class !== e.cls || o_score !== e.score) begin
      n_mis++;
      $display("FAIL empty_run: valid=%0b class=%0d score=%h, required 1 %0d %h",
               o_valid, o_class, o_score, e.cls, e.score);
    end
    ack();
  endtask

  task automatic test_rst_collect();
    beat(8'd1, 1'b0); beat(8'd2, 1'b0); beat(8'd250, 1'b0); beat(8'd3, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({o_ready, o_valid, o_class, o_score} !== {1'b1, 1'b0, 4'd0, 8'h00}) begin
      n_mis++;
      $display("FAIL rst_collect: ready=%0b valid=%0b class=%0d score=%h, required 1 0 0 00",
               o_ready, o_valid, o_class, o_score);
    end
    rst = 1'b0;
    beat(8'd5, 1'b0); beat(8'd1, 1'b0); beat(8'd1, 1'b0);
    sb.push_back('{4'd0, 8'd5});
    start_only();
    e = sb.pop_front();
    n_cmp++;
    if (o_valid !== 1'b1 || o_class !== e.cls || o_score !== e.score) begin
      n_mis++;
      $display("FAIL post_rst_run: valid=%0b class=%0d score=%h, required 1 %0d %h",
               o_valid, o_class, o_score, e.cls, e.score);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_signed();
    test_handshake();
    test_edges();
    test_rst_collect();
    n_cmp++;
    if (sb.size() != 0) begin
      n_mis++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
